// File: rtl/register_word_port.sv
// register_word_port: splits byte/16-bit register requests into byte-wide cycles on the 256x8 register-file RAM.
// Build option: `define REGFILE_CLEAR_ON_RESET_EN zero-fills the whole RAM after reset before accepting requests.
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   CLEAR  | zero-filling 0x00..0xFF after reset (option only)
//   RD_A   | first read address on the RAM port
//   RD_B   | second read address out, first byte arriving
//   RD_C   | last byte arriving, response issued on exit
//   WR_A   | first (or only) byte being written
//   WR_B   | second byte of a word being written
module register_word_port #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [3:0]  req_level,
  input  logic [3:0]  req_index,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        ram_write_en,
  output logic [7:0]  ram_address,
  output logic [7:0]  ram_data_in,
  input  logic [7:0]  ram_data_out
);

`ifdef REGFILE_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RD_A, S_RD_B, S_RD_C, S_WR_A, S_WR_B
  } state_t;
  localparam state_t RESET_STATE = S_CLEAR;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_WR_A, S_WR_B
  } state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t      state_q, state_d;
  logic        write_q, word_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  first_q, first_d;
  logic        accept;

  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        we_q, we_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d;

  logic [7:0]  req_addr;
  logic [7:0]  req_first_byte;
  logic [7:0]  odd_byte;

`ifdef REGFILE_CLEAR_ON_RESET_EN
  logic [7:0]  clr_left_q, clr_left_d;
`endif

  assign accept   = req_valid && (state_q == S_IDLE);
  assign req_addr = req_word ? {req_level, req_index[3:1], 1'b0} : {req_level, req_index};

  // Even address carries the high byte when BIG_ENDIAN, the low byte otherwise.
  assign req_first_byte = !req_word ? req_wdata[7:0]
                        : (BIG_ENDIAN ? req_wdata[15:8] : req_wdata[7:0]);
  assign odd_byte       = BIG_ENDIAN ? wdata_q[7:0] : wdata_q[15:8];

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    we_d        = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    clr_left_d  = clr_left_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ram_addr_d = req_addr;
          if (req_write) begin
            we_d      = 1'b1;
            ram_din_d = req_first_byte;
            state_d   = S_WR_A;
          end else begin
            state_d   = S_RD_A;
          end
        end
      end
`ifdef REGFILE_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        // The 0xFF write is on the port this cycle: leave once it lands.
        if (we_q && (ram_addr_q == 8'hFF)) begin
          state_d = S_IDLE;
        end else begin
          we_d       = 1'b1;
          ram_addr_d = ~clr_left_q;
          ram_din_d  = 8'h00;
          clr_left_d = clr_left_q - 8'd1;
        end
      end
`endif
      S_WR_A: begin
        if (word_q) begin
          we_d       = 1'b1;
          ram_addr_d = {addr_q[7:1], 1'b1};
          ram_din_d  = odd_byte;
          state_d    = S_WR_B;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR_B: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_RD_A: begin
        if (word_q) begin
          ram_addr_d = {addr_q[7:1], 1'b1};
          state_d    = S_RD_B;
        end else begin
          state_d    = S_RD_C;
        end
      end
      S_RD_B: begin
        first_d = ram_data_out;
        state_d = S_RD_C;
      end
      S_RD_C: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
        if (!word_q)
          rsp_rdata_d = {8'h00, ram_data_out};
        else if (BIG_ENDIAN)
          rsp_rdata_d = {first_q, ram_data_out};
        else
          rsp_rdata_d = {ram_data_out, first_q};
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      write_q     <= 1'b0;
      word_q      <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 16'h0000;
      first_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      we_q        <= 1'b0;
      ram_addr_q  <= 8'h00;
      ram_din_q   <= 8'h00;
`ifdef REGFILE_CLEAR_ON_RESET_EN
      clr_left_q  <= 8'hFF;
`endif
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
`ifdef REGFILE_CLEAR_ON_RESET_EN
      clr_left_q  <= clr_left_d;
`endif
      if (accept) begin
        write_q <= req_write;
        word_q  <= req_word;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign ram_write_en = we_q;
  assign ram_address  = ram_addr_q;
  assign ram_data_in  = ram_din_q;

endmodule

// File: tb/tb_register_word_port.sv
// Bench for register_word_port: a big-endian and a little-endian instance driven side by side,
// each with its own 256x8 RAM, checked every cycle against a transaction-level model.
module tb_register_word_port;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_word = 1'b0;
  logic [3:0]  req_level = 4'h0, req_index = 4'h0;
  logic [15:0] req_wdata = 16'h0000;

  logic        r0_ready, r0_rsp, r0_we, r1_ready, r1_rsp, r1_we;
  logic [15:0] r0_rdata, r1_rdata;
  logic [7:0]  r0_addr, r0_din, r0_dout, r1_addr, r1_din, r1_dout;
  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];

  int checks = 0;
  int failures = 0;

`ifdef REGFILE_CLEAR_ON_RESET_EN
  localparam bit RESET_RDY = 1'b0;
`else
  localparam bit RESET_RDY = 1'b1;
`endif

  always #5 clock = ~clock;

  register_word_port #(.BIG_ENDIAN(1'b1)) u_be (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(r0_ready),
    .req_write(req_write), .req_word(req_word), .req_level(req_level), .req_index(req_index),
    .req_wdata(req_wdata), .rsp_valid(r0_rsp), .rsp_rdata(r0_rdata), .ram_write_en(r0_we),
    .ram_address(r0_addr), .ram_data_in(r0_din), .ram_data_out(r0_dout));

  register_word_port #(.BIG_ENDIAN(1'b0)) u_le (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(r1_ready),
    .req_write(req_write), .req_word(req_word), .req_level(req_level), .req_index(req_index),
    .req_wdata(req_wdata), .rsp_valid(r1_rsp), .rsp_rdata(r1_rdata), .ram_write_en(r1_we),
    .ram_address(r1_addr), .ram_data_in(r1_din), .ram_data_out(r1_dout));

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'hF5;
      mem1[i] = 8'hF5;
    end
  end

  always @(posedge clock) begin
    if (r0_we) mem0[r0_addr] <= r0_din;
    r0_dout <= mem0[r0_addr];
  end

  always @(posedge clock) begin
    if (r1_we) mem1[r1_addr] <= r1_din;
    r1_dout <= mem1[r1_addr];
  end

  // ---------------- transaction-level model ----------------
  int          m_k, m_n, m_clr_k;
  bit          clearing;
  logic        m_wr, m_wd, m_rsp;
  logic [7:0]  m_a0;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata [2];
  logic [7:0]  sh [2][256];

  task automatic model_reset();
    m_k = 0;
    m_rsp = 1'b0;
    m_rdata[0] = 16'h0000;
    m_rdata[1] = 16'h0000;
    m_clr_k = 0;
    clearing = !RESET_RDY;
  endtask

  // Instance 0 is big-endian (even address = high byte), instance 1 little-endian.
  function automatic logic [7:0] wbyte(input int d, input int k);
    logic [7:0] hi, lo;
    hi = m_wdata[15:8];
    lo = m_wdata[7:0];
    if (!m_wd) return lo;
    if (k == 1) return (d == 0) ? hi : lo;
    return (d == 0) ? lo : hi;
  endfunction

  function automatic logic [15:0] rval(input int d);
    logic [7:0] ev, od;
    ev = sh[d][m_a0];
    od = sh[d][m_a0 | 8'h01];
    if (!m_wd) return {8'h00, ev};
    return (d == 0) ? {ev, od} : {od, ev};
  endfunction

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) sh[d][i] = 8'hF5;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rsp = 1'b0;
      if (clearing) begin
        if (m_clr_k >= 1) begin
          sh[0][8'(m_clr_k - 1)] = 8'h00;
          sh[1][8'(m_clr_k - 1)] = 8'h00;
        end
        m_clr_k++;
        if (m_clr_k == 257) clearing = 1'b0;
      end else if (m_k > 0) begin
        if (m_wr && (m_k == 1 || (m_wd && m_k == 2)))
          for (int d = 0; d < 2; d++)
            sh[d][(m_k == 1) ? m_a0 : (m_a0 | 8'h01)] = wbyte(d, m_k);
        if (m_k == m_n) begin
          m_k = 0;
          m_rsp = 1'b1;
          if (!m_wr) begin
            m_rdata[0] = rval(0);
            m_rdata[1] = rval(1);
          end
        end else begin
          m_k++;
        end
      end else if (req_valid) begin
        m_wr    = req_write;
        m_wd    = req_word;
        m_wdata = req_wdata;
        m_a0    = req_word ? {req_level, req_index[3:1], 1'b0} : {req_level, req_index};
        m_n     = req_write ? (req_word ? 2 : 1) : (req_word ? 3 : 2);
        m_k     = 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input logic rdy, input logic rv, input logic [15:0] rd,
                     input logic we, input logic [7:0] a, input logic [7:0] di);
    logic       exp_we, rd_cyc;
    logic [7:0] exp_a;
    exp_we = clearing ? (m_clr_k >= 1)
                      : (m_k > 0 && m_wr && (m_k == 1 || (m_wd && m_k == 2)));
    rd_cyc = !clearing && m_k > 0 && !m_wr && (m_k == 1 || (m_wd && m_k == 2));
    exp_a  = (m_k == 1) ? m_a0 : (m_a0 | 8'h01);
    chk($sformatf("req_ready[%0d]", d), rdy, !clearing && m_k == 0);
    chk($sformatf("rsp_valid[%0d]", d), rv, m_rsp);
    chk($sformatf("rsp_rdata[%0d]", d), rd, m_rdata[d]);
    chk($sformatf("ram_write_en[%0d]", d), we, exp_we);
    if (!reset_n) begin
      chk($sformatf("rst_address[%0d]", d), a, 8'h00);
      chk($sformatf("rst_data_in[%0d]", d), di, 8'h00);
    end else if (clearing) begin
      if (exp_we) begin
        chk($sformatf("clr_address[%0d]", d), a, 8'(m_clr_k - 1));
        chk($sformatf("clr_data_in[%0d]", d), di, 8'h00);
      end
    end else begin
      if (exp_we) begin
        chk($sformatf("wr_address[%0d]", d), a, exp_a);
        chk($sformatf("wr_data_in[%0d]", d), di, wbyte(d, m_k));
      end
      if (rd_cyc) chk($sformatf("rd_address[%0d]", d), a, exp_a);
    end
  endtask

  always @(negedge clock) begin
    cmp(0, r0_ready, r0_rsp, r0_rdata, r0_we, r0_addr, r0_din);
    cmp(1, r1_ready, r1_rsp, r1_rdata, r1_we, r1_addr, r1_din);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wr, input bit wd, input logic [3:0] lv, input logic [3:0] ix,
                       input logic [15:0] data);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_level = lv;
    req_index = ix;
    req_wdata = data;
    n = 0;
    while (!r0_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!r0_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=req_ready_low required=req_ready_high at %0t", $time);
    end
    @(posedge clock);
  endtask

  task automatic settle();
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic lit_read(input bit wd, input logic [3:0] lv, input logic [3:0] ix,
                          input int edges, input logic [15:0] e0, input logic [15:0] e1);
    issue(1'b0, wd, lv, ix, 16'h0000);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (edges) @(posedge clock);
    #1;
    chk("lit_rsp_valid", {r1_rsp, r0_rsp}, 2'b11);
    chk("lit_rdata_be", r0_rdata, e0);
    chk("lit_rdata_le", r1_rdata, e1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_ready", r0_ready, RESET_RDY);
    chk("reset_rdata", r0_rdata, 16'h0000);
    reset_n = 1'b1;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    repeat (256) @(negedge clock);
    chk("clear_busy_256", r0_ready, 1'b0);
    @(negedge clock);
    chk("clear_done_257", r0_ready, 1'b1);
    repeat (2) @(negedge clock);
`else
    repeat (2) @(negedge clock);
`endif

    // byte write 0x3C to level 2 index 5, then read it back
    issue(1'b1, 1'b0, 4'd2, 4'd5, 16'h003C);
    #1;
    chk("bw_we", {r1_we, r0_we}, 2'b11);
    chk("bw_addr", r0_addr, 8'h25);
    chk("bw_data", r0_din, 8'h3C);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("bw_rsp", {r1_rsp, r0_rsp}, 2'b11);
    chk("bw_we_off", r0_we, 1'b0);
    repeat (3) @(negedge clock);
    lit_read(1'b0, 4'd2, 4'd5, 2, 16'h003C, 16'h003C);

    // word write 0xBEEF to level 1 index 6, read back with index 7
    issue(1'b1, 1'b1, 4'd1, 4'd6, 16'hBEEF);
    #1;
    chk("ww_addr0", r0_addr, 8'h16);
    chk("ww_be_byte0", r0_din, 8'hBE);
    chk("ww_le_byte0", r1_din, 8'hEF);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("ww_addr1", r0_addr, 8'h17);
    chk("ww_be_byte1", r0_din, 8'hEF);
    chk("ww_we1", r0_we, 1'b1);
    repeat (3) @(negedge clock);
    lit_read(1'b1, 4'd1, 4'd7, 3, 16'hBEEF, 16'hBEEF);

    // word 0x1234 at 0x00, byte read of 0x01
    issue(1'b1, 1'b1, 4'd0, 4'd0, 16'h1234);
    settle();
    lit_read(1'b0, 4'd0, 4'd1, 2, 16'h0034, 16'h0012);

    // never-written location
`ifdef REGFILE_CLEAR_ON_RESET_EN
    lit_read(1'b0, 4'd10, 4'd7, 2, 16'h0000, 16'h0000);
`else
    lit_read(1'b0, 4'd10, 4'd7, 2, 16'h00F5, 16'h00F5);
`endif

    // back-to-back with req_valid held high throughout
    issue(1'b0, 1'b1, 4'd1, 4'd6, 16'h0000);
    issue(1'b1, 1'b0, 4'd3, 4'd0, 16'h0055);
    issue(1'b0, 1'b0, 4'd3, 4'd0, 16'h0000);
    settle();
    chk("b2b_rdata", r0_rdata, 16'h0055);

    // reset between the two bytes of a word write
    issue(1'b1, 1'b1, 4'd4, 4'd2, 16'hA1B2);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_we", {r1_we, r0_we}, 2'b00);
    chk("midrst_rsp", {r1_rsp, r0_rsp}, 2'b00);
    chk("midrst_ready", r0_ready, RESET_RDY);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    repeat (260) @(negedge clock);
    lit_read(1'b1, 4'd4, 4'd2, 3, 16'h0000, 16'h0000);
`else
    repeat (2) @(negedge clock);
    lit_read(1'b1, 4'd4, 4'd2, 3, 16'hA1F5, 16'hF5B2);
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
